// File: rtl/cascade_stage_ctrl.sv
// Viola-Jones cascade stage controller: sequences one detection window through
// the cascade, accumulating weak-classifier votes and deciding at each stage threshold.
module cascade_stage_ctrl #(
  parameter int SUM_WIDTH       = 24,
  parameter int ID_WIDTH        = 16,
  parameter int STAGE_CNT       = 22,
  parameter int STAGE_W         = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 win_val_i,
  input  logic [ID_WIDTH-1:0]  win_id_i,
  output logic                 win_ready_o,
  input  logic                 rom_val_i,
  input  logic                 stage_val_i,
  input  logic                 stage_last_i,
  input  logic [SUM_WIDTH-1:0] stage_thr_i,
  input  logic                 feat_val_i,
  input  logic [SUM_WIDTH-1:0] feat_value_i,
  output logic                 next_stage_o,
  output logic                 break_o,
  output logic                 wait_o,
  output logic                 res_val_o,
  input  logic                 res_ready_i,
  output logic                 res_face_o,
  output logic [STAGE_W-1:0]   res_stage_o,
  output logic [ID_WIDTH-1:0]  res_id_o,
  output logic                 err_o,
  output logic                 busy_o
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]   OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]   OUT_WAIT  = OUT_W'(MAX_OUTSTANDING - 1);
  localparam logic [STAGE_W-1:0] STAGE_TOP = STAGE_W'(STAGE_CNT - 1);
  localparam logic [SUM_WIDTH-1:0] SUM_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic [SUM_WIDTH-1:0] SUM_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DECIDE, REPORT} state_t;

  state_t                 state, state_next;
  logic [SUM_WIDTH-1:0]   sum, sum_base, sum_next;
  logic [SUM_WIDTH:0]     sum_wide;
  logic [SUM_WIDTH-1:0]   thr_q;
  logic                   last_q;
  logic [OUT_W-1:0]       outstanding, outstanding_next;
  logic [STAGE_W-1:0]     stage_idx;
  logic [ID_WIDTH-1:0]    id_q;
  logic                   face_q;
  logic                   err_q;

  logic active, feat_err, feat_take, pass, advance, start;

  assign active    = (state == RUN) || (state == DECIDE);
  // A contribution with nothing in flight is a protocol violation and is dropped.
  assign feat_err  = active && feat_val_i && !rom_val_i && (outstanding == '0);
  assign feat_take = active && feat_val_i && !feat_err;
  assign pass      = $signed(sum) >= $signed(thr_q);
  assign advance   = (state == DECIDE) && pass && !last_q;
  assign start     = (state == IDLE) && win_val_i;

  // Saturating signed add; a stage advance clears the sum before the add.
  assign sum_base = advance ? '0 : sum;
  assign sum_wide = {sum_base[SUM_WIDTH-1], sum_base}
                  + {feat_value_i[SUM_WIDTH-1], feat_value_i};

  always_comb begin
    sum_next = sum_base;
    if (feat_take) begin
      if (sum_wide[SUM_WIDTH] != sum_wide[SUM_WIDTH-1])
        sum_next = sum_wide[SUM_WIDTH] ? SUM_MIN : SUM_MAX;
      else
        sum_next = sum_wide[SUM_WIDTH-1:0];
    end
  end

  always_comb begin
    outstanding_next = outstanding;
    if (active) begin
      if (rom_val_i && !feat_take && (outstanding != OUT_MAX))
        outstanding_next = outstanding + 1'b1;
      else if (!rom_val_i && feat_take)
        outstanding_next = outstanding - 1'b1;
    end
  end

  // NOTE: every output and next-state value gets a default first so no path
  // through the case leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_next   = state;
    win_ready_o  = 1'b0;
    break_o      = 1'b0;
    wait_o       = 1'b0;
    next_stage_o = 1'b0;
    res_val_o    = 1'b0;
    unique case (state)
      IDLE: begin
        win_ready_o = rst_n_i;
        break_o     = 1'b1;
        wait_o      = 1'b1;
        if (win_val_i) state_next = RUN;
      end
      RUN: begin
        wait_o = (outstanding >= OUT_WAIT);
        if (stage_val_i && (outstanding == '0) && !feat_val_i) state_next = DECIDE;
      end
      DECIDE: begin
        wait_o = 1'b1;
        if (advance) begin
          next_stage_o = 1'b1;
          state_next   = RUN;
        end else begin
          state_next = REPORT;
        end
      end
      REPORT: begin
        res_val_o = 1'b1;
        break_o   = 1'b1;
        wait_o    = 1'b1;
        if (res_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      sum         <= '0;
      thr_q       <= '0;
      last_q      <= 1'b0;
      outstanding <= '0;
      stage_idx   <= '0;
      id_q        <= '0;
      face_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        id_q        <= win_id_i;
        sum         <= '0;
        outstanding <= '0;
        stage_idx   <= '0;
        err_q       <= 1'b0;
        face_q      <= 1'b0;
      end else if (active) begin
        sum         <= sum_next;
        outstanding <= outstanding_next;
        if (feat_err) err_q <= 1'b1;
        if (advance && (stage_idx != STAGE_TOP)) stage_idx <= stage_idx + 1'b1;
        if (state == DECIDE && !advance) face_q <= pass && last_q;
      end
      if (state == RUN && state_next == DECIDE) begin
        thr_q  <= stage_thr_i;
        last_q <= stage_last_i;
      end
    end
  end

  assign res_face_o  = face_q;
  assign res_stage_o = stage_idx;
  assign res_id_o    = id_q;
  assign err_o       = err_q;
  assign busy_o      = (state != IDLE);

endmodule

// File: doc/cascade_stage_ctrl.md
Name: cascade_stage_ctrl

Overview:
- Sequences one Viola-Jones cascade evaluation per detection window. Drives the ROM address walker through next_stage/break/wait, and accumulates weak-classifier contributions from the feature pipeline.
- At each stage-threshold word it compares the stage sum against the threshold, then either advances to the next stage or rejects the window.
- Sits between the window scheduler (upstream), the ROM address walker and feature pipeline (side), and the detection result sink (downstream).

Parameters:
SUM_WIDTH, 24, signed width of stage sum, feature contribution and stage threshold
ID_WIDTH, 16, window identifier width
STAGE_CNT, 22, number of cascade stages
STAGE_W, 5, width of stage index (ceil log2 STAGE_CNT)
MAX_OUTSTANDING, 4, max ROM reads in flight in the feature pipeline (>=2)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
win_val_i  in  1  new window request valid
win_id_i  in  ID_WIDTH  window identifier
win_ready_o  out  1  controller can accept a window
rom_val_i  in  1  a classifier ROM word was issued into the feature pipeline
stage_val_i  in  1  current ROM word is a stage threshold (walker stalled on it)
stage_last_i  in  1  threshold belongs to final stage
stage_thr_i  in  SUM_WIDTH  signed stage threshold
feat_val_i  in  1  weak-classifier contribution valid
feat_value_i  in  SUM_WIDTH  signed contribution
next_stage_o  out  1  advance walker past threshold word (1-cycle pulse)
break_o  out  1  rewind/hold walker at address 0
wait_o  out  1  stall walker address increment
res_val_o  out  1  result valid
res_ready_i  in  1  result accepted
res_face_o  out  1  1 = window passed all stages
res_stage_o  out  STAGE_W  stage index at which decision was made
res_id_o  out  ID_WIDTH  window identifier of result
err_o  out  1  sticky protocol error (feat_val_i with nothing outstanding)
busy_o  out  1  state != IDLE

Behaviour:

Reset values:
- rst_n_i low asynchronously forces state IDLE.
- Outputs: break_o=1, wait_o=1, win_ready_o=0 during reset, then 1 in IDLE.
- All other outputs are 0: next_stage_o, res_*, err_o, busy_o.
- Internal state is 0: sum, outstanding counter, stage index.
- Reset mid-operation discards the window silently; no result is emitted.

States:
- IDLE: break_o=1, wait_o=1, win_ready_o=1.
  - On win_val_i: capture win_id_i, clear sum/outstanding/stage_idx/err_o, go to RUN.
- RUN: break_o=0.
  - wait_o=1 when outstanding >= MAX_OUTSTANDING-1 (one cycle of margin for the registered rom_val_i), else 0.
  - Go to DECIDE when stage_val_i=1 and outstanding=0 and feat_val_i=0. Capture stage_thr_i and stage_last_i in that cycle.
- DECIDE: single cycle, wait_o=1.
  - sum >= thr and !last: next_stage_o=1, clear sum, stage_idx+1, go to RUN.
  - sum >= thr and last: res_face_o=1, go to REPORT.
  - sum < thr: res_face_o=0, go to REPORT.
- REPORT: res_val_o=1, break_o=1, wait_o=1, win_ready_o=0. res_face_o, res_stage_o (= stage_idx) and res_id_o are held stable.
  - On res_ready_i go to IDLE.
  - A new window is not accepted in the same cycle.

Outstanding counter:
- +1 on rom_val_i, -1 on feat_val_i, unchanged when both assert together.
- Counts only in RUN and DECIDE; cleared on window start.
- Width is ceil log2(MAX_OUTSTANDING+1).

Accumulator:
- On feat_val_i, sum <= sum + feat_value_i, signed.
- Saturates at +2^(SUM_WIDTH-1)-1 / -2^(SUM_WIDTH-1). Never wraps.
- Comparison is signed, threshold inclusive (>=).

Boundary conditions:
- feat_val_i with outstanding=0 (and no simultaneous rom_val_i): set err_o, ignore the contribution, counter stays 0.
- stage_val_i while outstanding>0: no decision; remain in RUN until drained.
- stage_idx saturates at STAGE_CNT-1.
- stage_last_i without a pass still yields res_face_o=0.
- rom_val_i/feat_val_i outside RUN/DECIDE are ignored.
- next_stage_o and break_o are never asserted together.

Latency:
- stage_val_i with pipeline drained → next_stage_o or REPORT entry: exactly 1 cycle later (DECIDE).
- res_val_o rises 2 cycles after the qualifying stage_val_i.

Test Plan:
1. Window id 5; stage 0 contributions +10,+20,-5 drained; stage_val_i with thr=20, last=0 → DECIDE next cycle, next_stage_o 1-cycle pulse, sum back to 0, stage_idx=1, no result.
2. Window id 7; contributions +10,+5; thr=20 → break_o=1, res_val_o=1, res_face_o=0, res_stage_o=0, res_id_o=7.
3. STAGE_CNT=2; pass stage 0 (sum 30 ≥ 20); stage 1 sum 40 ≥ thr 40, last=1 → res_face_o=1, res_stage_o=1, exactly one next_stage_o pulse in the window.
4. MAX_OUTSTANDING=4; three rom_val_i with feat_val_i withheld → wait_o=1 when outstanding reaches 3; stage_val_i asserted meanwhile → no DECIDE until three feat_val_i arrive; decision 1 cycle after drain.
5. SUM_WIDTH=8; contributions +100,+100 → sum=127, not -56; then -128,-128,-128 → sum=-128. Also feat_val_i with outstanding=0 → err_o=1 and sum unchanged.
6. REPORT with res_ready_i low for 5 cycles → res_* stable, break_o=1, win_ready_o=0, win_val_i ignored. Then rst_n_i pulsed low mid-RUN → immediately IDLE with reset values, no res_val_o.
